mdio_sched: RTL and testbench
=============================

# mdio_sched

Shared-access scheduler for the single SMI/MDIO transaction engine on the PHY management bus. It arbitrates NREQ client register requests round-robin and inserts a periodic link-status poll of PHY register 1. It sequences each transaction through the engine's trg/ready handshake and returns read data, ack and timeout status to the winning client. It sits between the clk1m management domain clients (PHY init, debug, stats) and the SMI transaction engine.

## Interface
- NREQ, 4, number of client requesters (1..8)
- POLL_DIV, 100000, clk cycles between link polls (100 ms at 1 MHz)
- TIMEOUT, 200, max clk cycles a transaction may stay in BUSY
- clk  in  1  management clock (1 MHz, same as MDC)
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-client request level; held with its command until done
- req_rw  in  NREQ  per-client direction, 1 = read, 0 = write
- req_adr  in  5*NREQ  per-client register address, client i at [5i+4:5i]
- req_wdata  in  16*NREQ  per-client write data, client i at [16i+15:16i]
- gnt  out  NREQ  one-hot, high from command latch through DONE
- done  out  NREQ  one-cycle completion pulse to granted client
- rsp_rdata  out  16  read data of last completed transaction
- rsp_ack  out  1  PHY acknowledged last transaction
- rsp_timeout  out  1  last transaction ended by timeout
- link_up  out  1  reg1 bit 2 from last successful poll
- poll_busy  out  1  current transaction is the internal poll
- eng_trg  out  1  transaction request to SMI engine
- eng_rw  out  1  1 = read, 0 = write
- eng_reg_adr  out  5  register address to engine
- eng_wdata  out  16  write data to engine
- eng_ready  in  1  engine frame complete
- eng_ack  in  1  engine saw PHY turnaround ack
- eng_rdata  in  16  engine read data

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: eng_trg=0. If poll_due, latch poll command (rw=1, adr=1), poll_busy=1, go BUSY. Otherwise, if any req, select first set bit scanning from rr_ptr+1 upward with wrap mod NREQ; latch rw/adr/wdata; set gnt[i]; rr_ptr<=i; go BUSY. Otherwise stay.
- Poll has strict priority over clients, but never preempts a transaction in flight.
- BUSY: eng_trg=1, eng_* driven from latched registers (stable for whole transaction). armed sets when eng_ready==0 is sampled. Completion when armed && eng_ready==1: capture eng_rdata->rsp_rdata, eng_ack->rsp_ack, rsp_timeout=0, go DONE. A stale eng_ready=1 from the previous frame must not complete a new transaction.
- Timeout: busy_cnt counts BUSY cycles; at busy_cnt==TIMEOUT-1 without completion -> rsp_timeout=1, rsp_ack=0, rsp_rdata unchanged, go DONE.
- DONE (1 cycle): eng_trg=0; done[i] pulses for client transactions; for poll, link_up<=rsp_ack&&!timeout ? eng_rdata[2] : 0, poll_due<=0; clear gnt, poll_busy, armed, busy_cnt; go IDLE.
- Poll timer: poll_cnt decrements every cycle, in every state; at 0 reloads POLL_DIV-1 and sets poll_due (sticky; a second expiry while due is absorbed).
- Client deasserting req during BUSY: transaction still completes; done still pulses.

## Timing
- Reset values: state IDLE, eng_trg/gnt/done/rsp_*/link_up/poll_busy = 0, eng_rw=1, eng_reg_adr=1, eng_wdata=0, rr_ptr=NREQ-1 (first client grant goes to req0), poll_due=1 (first transaction after reset is a poll), poll_cnt=POLL_DIV-1.
- req sampled in IDLE -> gnt and eng_trg high the next cycle.
- eng_ready high (armed) sampled -> done pulse and rsp_* valid the next cycle; rsp_* hold until the next completion.
- eng_trg low for at least one cycle (DONE) between consecutive transactions; next IDLE decision one cycle after DONE.
- Minimum transaction: 4 cycles IDLE-to-IDLE given one-cycle engine ready drop.
- rst mid-transaction: immediate return to reset values; eng_trg drops next cycle; no done pulse.

## Test plan
- Reset, no client req, engine returns ready with ack=1, rdata=16'h0004 -> first transaction is poll (eng_reg_adr=1, eng_rw=1), link_up=1 after DONE, no done pulses.
- All four req high continuously, poll_due cleared -> grant order 0,1,2,3,0; each done pulse on matching index; eng_reg_adr/eng_wdata match granted client.
- Client 2 write adr=31 wdata=16'h0007, eng_ready held high at grant then low 3 cycles then high -> completion only on second high; done[2] pulses once.
- eng_ready never rises, TIMEOUT=200 -> DONE exactly 200 BUSY cycles after entry, rsp_timeout=1, rsp_ack=0; poll variant drives link_up=0.
- POLL_DIV=50, client 1 transaction in flight when poll_cnt expires -> client 1 completes first, poll issued next ahead of pending client 3.
- rst asserted in BUSY -> next cycle eng_trg=0, gnt=0, no done; after release first transaction is poll.

Source files
------------

// File: rtl/mdio_sched.sv
// mdio_sched: shares one SMI/MDIO transaction engine between NREQ clients and an internal
// periodic link-status poll of PHY register 1.
//
// Ports:
//   clk_i, rst_i          management clock, synchronous active-high reset
//   req_i                 per-client request level, held with its command until done
//   req_rw_i              per-client direction (1 = read)
//   req_adr_i             per-client 5-bit register address, client i at [5i+4:5i]
//   req_wdata_i           per-client 16-bit write data, client i at [16i+15:16i]
//   gnt_o                 one-hot grant, high from command latch through DONE
//   done_o                one-cycle completion pulse to the granted client
//   rsp_rdata_o           read data of the last completed transaction
//   rsp_ack_o             PHY acknowledged the last transaction
//   rsp_timeout_o         last transaction ended by timeout
//   link_up_o             reg1 bit 2 from the last successful poll
//   poll_busy_o           current transaction is the internal poll
//   eng_trg_o             transaction request to the SMI engine
//   eng_rw_o              engine direction (1 = read)
//   eng_reg_adr_o         engine register address
//   eng_wdata_o           engine write data
//   eng_ready_i           engine frame complete
//   eng_ack_i             engine saw the PHY turnaround ack
//   eng_rdata_i           engine read data
module mdio_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned POLL_DIV = 100000,
  parameter int unsigned TIMEOUT  = 200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_rw_i,
  input  logic [5*NREQ-1:0]    req_adr_i,
  input  logic [16*NREQ-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic [15:0]          rsp_rdata_o,
  output logic                 rsp_ack_o,
  output logic                 rsp_timeout_o,
  output logic                 link_up_o,
  output logic                 poll_busy_o,
  output logic                 eng_trg_o,
  output logic                 eng_rw_o,
  output logic [4:0]           eng_reg_adr_o,
  output logic [15:0]          eng_wdata_o,
  input  logic                 eng_ready_i,
  input  logic                 eng_ack_i,
  input  logic [15:0]          eng_rdata_i
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned BusyW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PollW-1:0] PollReload = PollW'(POLL_DIV - 1);
  localparam logic [BusyW-1:0] BusyLast   = BusyW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0]  PtrInit    = IdxW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              poll_due_q, poll_due_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [BusyW-1:0]  busy_cnt_q, busy_cnt_d;
  logic              armed_q, armed_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              poll_busy_q, poll_busy_d;
  logic              eng_rw_q, eng_rw_d;
  logic [4:0]        eng_adr_q, eng_adr_d;
  logic [15:0]       eng_wdata_q, eng_wdata_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_ack_q, rsp_ack_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              link_up_q, link_up_d;

  // Per-client command fields as arrays so the winner can be selected by index.
  logic [4:0]  adr_arr   [NREQ];
  logic [15:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign adr_arr[g]   = req_adr_i[5*g +: 5];
    assign wdata_arr[g] = req_wdata_i[16*g +: 16];
  end

  // Round-robin pick: first requester scanning upward from rr_ptr+1, wrapping mod NREQ.
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NREQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    poll_due_d    = poll_due_q;
    poll_cnt_d    = poll_cnt_q;
    busy_cnt_d    = busy_cnt_q;
    armed_d       = armed_q;
    gnt_d         = gnt_q;
    poll_busy_d   = poll_busy_q;
    eng_rw_d      = eng_rw_q;
    eng_adr_d     = eng_adr_q;
    eng_wdata_d   = eng_wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_ack_d     = rsp_ack_q;
    rsp_timeout_d = rsp_timeout_q;
    link_up_d     = link_up_q;

    unique case (state_q)
      StIdle: begin
        // The poll wins over clients, but only ever from IDLE, so it never preempts.
        if (poll_due_q) begin
          poll_busy_d = 1'b1;
          eng_rw_d    = 1'b1;
          eng_adr_d   = 5'd1;
          eng_wdata_d = '0;
          armed_d     = 1'b0;
          busy_cnt_d  = '0;
          state_d     = StBusy;
        end else if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          rr_ptr_d        = pick_idx;
          eng_rw_d        = req_rw_i[pick_idx];
          eng_adr_d       = adr_arr[pick_idx];
          eng_wdata_d     = wdata_arr[pick_idx];
          armed_d         = 1'b0;
          busy_cnt_d      = '0;
          state_d         = StBusy;
        end
      end
      StBusy: begin
        // Completion needs a low-then-high on eng_ready so a stale ready is ignored.
        if (armed_q && eng_ready_i) begin
          rsp_rdata_d   = eng_rdata_i;
          rsp_ack_d     = eng_ack_i;
          rsp_timeout_d = 1'b0;
          state_d       = StDone;
        end else if (busy_cnt_q == BusyLast) begin
          rsp_timeout_d = 1'b1;
          rsp_ack_d     = 1'b0;
          state_d       = StDone;
        end else begin
          busy_cnt_d = busy_cnt_q + BusyW'(1);
          if (!eng_ready_i) begin
            armed_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (poll_busy_q) begin
          link_up_d  = (rsp_ack_q && !rsp_timeout_q) ? eng_rdata_i[2] : 1'b0;
          poll_due_d = 1'b0;
        end
        gnt_d       = '0;
        poll_busy_d = 1'b0;
        armed_d     = 1'b0;
        busy_cnt_d  = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Free-running poll timer; an expiry wins over the DONE clear so it is never lost.
    if (poll_cnt_q == '0) begin
      poll_cnt_d = PollReload;
      poll_due_d = 1'b1;
    end else begin
      poll_cnt_d = poll_cnt_q - PollW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      rr_ptr_q      <= PtrInit;
      poll_due_q    <= 1'b1;
      poll_cnt_q    <= PollReload;
      busy_cnt_q    <= '0;
      armed_q       <= 1'b0;
      gnt_q         <= '0;
      poll_busy_q   <= 1'b0;
      eng_rw_q      <= 1'b1;
      eng_adr_q     <= 5'd1;
      eng_wdata_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_ack_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      poll_due_q    <= poll_due_d;
      poll_cnt_q    <= poll_cnt_d;
      busy_cnt_q    <= busy_cnt_d;
      armed_q       <= armed_d;
      gnt_q         <= gnt_d;
      poll_busy_q   <= poll_busy_d;
      eng_rw_q      <= eng_rw_d;
      eng_adr_q     <= eng_adr_d;
      eng_wdata_q   <= eng_wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_ack_q     <= rsp_ack_d;
      rsp_timeout_q <= rsp_timeout_d;
      link_up_q     <= link_up_d;
    end
  end

  assign eng_trg_o     = (state_q == StBusy);
  assign gnt_o         = gnt_q;
  assign done_o        = (state_q == StDone && !poll_busy_q) ? gnt_q : '0;
  assign poll_busy_o   = poll_busy_q;
  assign eng_rw_o      = eng_rw_q;
  assign eng_reg_adr_o = eng_adr_q;
  assign eng_wdata_o   = eng_wdata_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_ack_o     = rsp_ack_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign link_up_o     = link_up_q;

endmodule

// File: tb/tb_mdio_sched.sv
// tb_mdio_sched: directed table and corner sequences plus randomized traffic for mdio_sched,
// checked every cycle against a transaction-rule reference model.
module tb_mdio_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned PD = 50;
  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_rw = '0;
  logic [5*N-1:0]    req_adr = '0;
  logic [16*N-1:0]   req_wdata = '0;
  logic              eng_ready = 1'b1;
  logic              eng_ack = 1'b1;
  logic [15:0]       eng_rdata = 16'h0004;

  logic [N-1:0]      gnt, done;
  logic [15:0]       rsp_rdata;
  logic              rsp_ack, rsp_timeout, link_up, poll_busy;
  logic              eng_trg, eng_rw;
  logic [4:0]        eng_reg_adr;
  logic [15:0]       eng_wdata;

  mdio_sched #(.NREQ(N), .POLL_DIV(PD), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_rw_i     (req_rw),
    .req_adr_i    (req_adr),
    .req_wdata_i  (req_wdata),
    .gnt_o        (gnt),
    .done_o       (done),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_ack_o    (rsp_ack),
    .rsp_timeout_o(rsp_timeout),
    .link_up_o    (link_up),
    .poll_busy_o  (poll_busy),
    .eng_trg_o    (eng_trg),
    .eng_rw_o     (eng_rw),
    .eng_reg_adr_o(eng_reg_adr),
    .eng_wdata_o  (eng_wdata),
    .eng_ready_i  (eng_ready),
    .eng_ack_i    (eng_ack),
    .eng_rdata_i  (eng_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 engine busy, 2 completion cycle. who: client index, -1 for the poll.
  int          m_ph = 0, m_who = 0, m_ptr = N - 1, m_bcnt = 0, m_since = 0;
  bit          m_due = 1, m_armed = 0, m_ack = 0, m_tmo = 0, m_link = 0, m_rw = 1;
  logic [4:0]  m_adr = 5'd1;
  logic [15:0] m_wdata = '0, m_rdata = '0;

  task automatic model_reset();
    m_ph = 0; m_who = 0; m_ptr = N - 1; m_bcnt = 0; m_since = 0;
    m_due = 1; m_armed = 0; m_ack = 0; m_tmo = 0; m_link = 0; m_rw = 1;
    m_adr = 5'd1; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit expire;
    bit picked;
    if (rst) begin
      model_reset();
      return;
    end
    // Poll expiries land on every PD-th clock after reset release.
    expire = ((m_since + 1) % PD) == 0;
    m_since++;
    case (m_ph)
      0: begin
        if (m_due) begin
          m_who = -1; m_rw = 1; m_adr = 5'd1; m_wdata = '0;
          m_ph = 1; m_bcnt = 0; m_armed = 0;
        end else begin
          picked = 0;
          for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!picked && ((req >> i) & N'(1)) != 0) begin
              picked = 1;
              m_who = i; m_ptr = i;
              m_rw = ((req_rw >> i) & N'(1)) != 0;
              m_adr = 5'(req_adr >> (5 * i));
              m_wdata = 16'(req_wdata >> (16 * i));
              m_ph = 1; m_bcnt = 0; m_armed = 0;
            end
          end
        end
      end
      1: begin
        if (m_armed && eng_ready) begin
          m_rdata = eng_rdata; m_ack = eng_ack; m_tmo = 0; m_ph = 2;
        end else if (m_bcnt == TO - 1) begin
          m_tmo = 1; m_ack = 0; m_ph = 2;
        end else begin
          m_bcnt++;
          if (!eng_ready) m_armed = 1;
        end
      end
      default: begin
        if (m_who < 0) begin
          m_link = (m_ack && !m_tmo) ? eng_rdata[2] : 1'b0;
          m_due = 0;
        end
        m_ph = 0; m_armed = 0; m_bcnt = 0;
      end
    endcase
    if (expire) m_due = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [31:0] eg, ed;
      eg = (m_ph != 0 && m_who >= 0) ? (32'd1 << m_who) : 32'd0;
      ed = (m_ph == 2 && m_who >= 0) ? (32'd1 << m_who) : 32'd0;
      check("eng_trg", 32'(eng_trg), 32'(m_ph == 1));
      check("gnt", 32'(gnt), eg);
      check("done", 32'(done), ed);
      check("poll_busy", 32'(poll_busy), 32'(m_ph != 0 && m_who < 0));
      check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      check("rsp_ack", 32'(rsp_ack), 32'(m_ack));
      check("rsp_timeout", 32'(rsp_timeout), 32'(m_tmo));
      check("link_up", 32'(link_up), 32'(m_link));
      check("eng_rw", 32'(eng_rw), 32'(m_rw));
      check("eng_reg_adr", 32'(eng_reg_adr), 32'(m_adr));
      check("eng_wdata", 32'(eng_wdata), 32'(m_wdata));
    end
  end

  int done_total = 0;
  int done2_cnt  = 0;
  initial forever begin
    @(negedge clk);
    if (done !== '0) done_total++;
    if (done[2] === 1'b1) done2_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic wait_trg(output bit ok);
    int n;
    n = 0;
    while (eng_trg !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (eng_trg === 1'b1);
    if (!ok) bound_fail("wait_trg");
  endtask

  // Serve the next transaction: keep ready high for 'stale' cycles, drop it for 'drop' cycles,
  // then raise it. Returns at the completion-cycle negedge.
  task automatic serve(input int stale, input int drop, input logic ack, input logic [15:0] rd,
                       output bit was_poll);
    bit ok;
    int n;
    was_poll = 0;
    wait_trg(ok);
    if (!ok) return;
    eng_ready = 1'b1; eng_ack = ack; eng_rdata = rd;
    repeat (stale) @(negedge clk);
    eng_ready = 1'b0;
    repeat (drop) @(negedge clk);
    eng_ready = 1'b1;
    n = 0;
    while (eng_trg === 1'b1 && n < 2 * TO) begin
      @(negedge clk);
      n++;
    end
    if (eng_trg === 1'b1) bound_fail("serve_complete");
    was_poll = poll_busy;
  endtask

  task automatic serve_client(input int stale, input int drop, input logic ack,
                              input logic [15:0] rd);
    bit wp;
    for (int a = 0; a < 4; a++) begin
      serve(stale, drop, ack, rd, wp);
      if (!wp) break;
    end
  endtask

  // Get 'mask' granted, completing any poll that goes first.
  task automatic get_grant(input logic [N-1:0] mask);
    bit ok, wp;
    for (int a = 0; a < 4; a++) begin
      wait_trg(ok);
      if (gnt === mask) break;
      serve(0, 1, 1'b1, 16'h0004, wp);
    end
  endtask

  typedef struct {
    int          exp_idx;
    int          drop;
    logic        ack;
    logic [15:0] rd;
  } rr_vec_t;

  rr_vec_t tbl[5];

  initial begin
    bit ok, wp;
    int n, d0;

    tbl[0] = '{exp_idx: 0, drop: 1, ack: 1'b1, rd: 16'h1111};
    tbl[1] = '{exp_idx: 1, drop: 2, ack: 1'b0, rd: 16'h2222};
    tbl[2] = '{exp_idx: 2, drop: 1, ack: 1'b1, rd: 16'h3333};
    tbl[3] = '{exp_idx: 3, drop: 3, ack: 1'b1, rd: 16'h4444};
    tbl[4] = '{exp_idx: 0, drop: 1, ack: 1'b0, rd: 16'h5555};

    // Reset state
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("rst_eng_trg", 32'(eng_trg), 32'd0);
    check("rst_adr", 32'(eng_reg_adr), 32'd1);
    check("rst_rw", 32'(eng_rw), 32'd1);
    rst = 1'b0;

    // First transaction after reset is the poll
    serve(0, 1, 1'b1, 16'h0004, wp);
    check("t1_poll_first", 32'(wp), 32'd1);
    check("t1_poll_adr", 32'(eng_reg_adr), 32'd1);
    check("t1_poll_rw", 32'(eng_rw), 32'd1);
    check("t1_no_done", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_link_up", 32'(link_up), 32'd1);
    check("t1_done_total", 32'(done_total), 32'd0);

    // Round-robin with all clients requesting
    req_adr   = {5'd11, 5'd10, 5'd9, 5'd8};
    req_wdata = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    req_rw    = 4'b1010;
    req       = 4'hF;
    for (int t = 0; t < 5; t++) begin
      serve_client(0, tbl[t].drop, tbl[t].ack, tbl[t].rd);
      check("rr_gnt", 32'(gnt), 32'd1 << tbl[t].exp_idx);
      check("rr_done", 32'(done), 32'd1 << tbl[t].exp_idx);
      check("rr_adr", 32'(eng_reg_adr), 32'(8 + tbl[t].exp_idx));
      check("rr_wdata", 32'(eng_wdata), 32'(16'hA000 + tbl[t].exp_idx));
      check("rr_rsp_ack", 32'(rsp_ack), 32'(tbl[t].ack));
      check("rr_rsp_rdata", 32'(rsp_rdata), 32'(tbl[t].rd));
    end
    req = '0;

    // Stale ready: client 2 write, ready high at grant, low 3 cycles, then high
    req_adr[14:10]   = 5'd31;
    req_wdata[47:32] = 16'h0007;
    req_rw[2]        = 1'b0;
    req              = 4'b0100;
    d0 = done2_cnt;
    serve_client(1, 3, 1'b1, 16'h00AA);
    check("t3_gnt", 32'(gnt), 32'd4);
    check("t3_adr", 32'(eng_reg_adr), 32'd31);
    check("t3_wdata", 32'(eng_wdata), 32'h7);
    check("t3_rw", 32'(eng_rw), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
    check("t3_done2_once", 32'(done2_cnt - d0), 32'd1);

    // Client timeout
    req = 4'b0010;
    for (int a = 0; a < 3; a++) begin
      wait_trg(ok);
      eng_ready = 1'b0;
      n = 0;
      while (eng_trg === 1'b1 && n < 2 * TO) begin
        n++;
        @(negedge clk);
      end
      wp = poll_busy;
      check("t4_busy_len", 32'(n), 32'(TO));
      check("t4_timeout", 32'(rsp_timeout), 32'd1);
      check("t4_ack", 32'(rsp_ack), 32'd0);
      if (!wp) begin
        check("t4_done", 32'(done), 32'd2);
        break;
      end
    end
    req = '0;
    eng_ready = 1'b1;

    // Poll restores link, then a timed-out poll drops it
    serve(0, 1, 1'b1, 16'h0004, wp);
    check("t4_poll_due", 32'(wp), 32'd1);
    @(negedge clk);
    check("t4_link_up", 32'(link_up), 32'd1);
    wait_trg(ok);
    eng_ready = 1'b0;
    n = 0;
    while (eng_trg === 1'b1 && n < 2 * TO) begin
      n++;
      @(negedge clk);
    end
    check("t4p_busy_len", 32'(n), 32'(TO));
    check("t4p_is_poll", 32'(poll_busy), 32'd1);
    check("t4p_timeout", 32'(rsp_timeout), 32'd1);
    @(negedge clk);
    check("t4p_link_down", 32'(link_up), 32'd0);
    eng_ready = 1'b1;

    // Poll expiry while client 1 is in flight, client 3 pending
    req = 4'b0010;
    get_grant(4'b0010);
    check("t5_gnt1", 32'(gnt), 32'd2);
    req = 4'b1010;
    eng_ready = 1'b0;
    repeat (60) @(negedge clk);
    eng_ready = 1'b1;
    n = 0;
    while (eng_trg === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_done1", 32'(done), 32'd2);
    req = 4'b1000;
    wait_trg(ok);
    check("t5_poll_next", 32'(poll_busy), 32'd1);
    check("t5_poll_no_gnt", 32'(gnt), 32'd0);
    serve(0, 1, 1'b1, 16'h0004, wp);
    wait_trg(ok);
    check("t5_client3", 32'(gnt), 32'd8);
    serve(0, 1, 1'b1, 16'h0333, wp);
    req = '0;

    // Reset during BUSY
    req = 4'b0001;
    get_grant(4'b0001);
    rst = 1'b1;
    d0 = done_total;
    @(negedge clk);
    check("t6_trg_drop", 32'(eng_trg), 32'd0);
    check("t6_gnt_clear", 32'(gnt), 32'd0);
    check("t6_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_trg(ok);
    check("t6_poll_first", 32'(poll_busy), 32'd1);
    check("t6_poll_adr", 32'(eng_reg_adr), 32'd1);
    serve(0, 1, 1'b1, 16'h0004, wp);
    check("t6_done_total", 32'(done_total - d0), 32'd0);
    req = '0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        req_rw    = N'($urandom);
        req_adr   = 20'($urandom);
        req_wdata = {$urandom, $urandom};
      end
      eng_ready = ($urandom_range(0, 9) < 6);
      eng_ack   = 1'($urandom);
      eng_rdata = 16'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
